// File: rtl/grf_wb_arbiter.sv
// Shares the register file write port between the W stage (priority) and a queued auxiliary source.
// Pipe writes pass through combinationally; aux writes drain from a FIFO, with a one-cycle pipe_hold on starvation.
module grf_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pipe_we,
    input  logic [4:0]                 pipe_a3,
    input  logic [31:0]                pipe_wd,
    input  logic [31:0]                pipe_pc,
    input  logic                       aux_valid,
    output logic                       aux_ready,
    input  logic [4:0]                 aux_a3,
    input  logic [31:0]                aux_wd,
    input  logic [31:0]                aux_pc,
    output logic                       grf_we,
    output logic [4:0]                 grf_a3,
    output logic [31:0]                grf_wd,
    output logic [31:0]                grf_pc,
    output logic                       pipe_hold,
    output logic [31:0]                aux_busy,
    output logic [$clog2(DEPTH+1)-1:0] aux_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]    a3_q [DEPTH];
    logic [4:0]    a3_d [DEPTH];
    logic [31:0]   wd_q [DEPTH];
    logic [31:0]   wd_d [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic [31:0]   pc_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    starve_q, starve_d;
    logic          hold_q, hold_d;

    logic head_vld, grant_head, grant_pipe, blocked, push;
    logic [AW-1:0] offset;

    assign aux_ready = !reset && (count_q < CW'(DEPTH));
    assign pipe_hold = hold_q;
    assign aux_count = count_q;

    always_comb begin
        head_vld   = (count_q != '0);
        // While holding, the head wins even if upstream wrongly keeps pipe_we high; that pipe write is lost.
        grant_head = !reset && head_vld && (hold_q || !pipe_we);
        grant_pipe = !reset && !grant_head && pipe_we;
        blocked    = head_vld && grant_pipe;
        push       = aux_valid && aux_ready;

        grf_we = grant_head || grant_pipe;
        grf_a3 = 5'd0;
        grf_wd = 32'd0;
        grf_pc = 32'd0;
        if (grant_head) begin
            grf_a3 = a3_q[rd_ptr_q];
            grf_wd = wd_q[rd_ptr_q];
            grf_pc = pc_q[rd_ptr_q];
        end else if (grant_pipe) begin
            grf_a3 = pipe_a3;
            grf_wd = pipe_wd;
            grf_pc = pipe_pc;
        end

        a3_d     = a3_q;
        wd_d     = wd_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            a3_d[wr_ptr_q] = aux_a3;
            wd_d[wr_ptr_q] = aux_wd;
            pc_d[wr_ptr_q] = aux_pc;
            wr_ptr_d       = wr_ptr_q + AW'(1);
        end
        if (grant_head) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(grant_head);

        starve_d = starve_q;
        if (!head_vld || grant_head) begin
            starve_d = 4'd0;
        end else if (blocked && starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end

        hold_d = hold_q;
        if (grant_head) begin
            hold_d = 1'b0;
        end else if (blocked && starve_q == 4'(STARVE_MAX - 1)) begin
            hold_d = 1'b1;
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        aux_busy = 32'd0;
        offset   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = AW'(i) - rd_ptr_q;
            if ((CW'(offset) < count_q) && (a3_q[i] != 5'd0)) begin
                aux_busy[a3_q[i]] = 1'b1;
            end
        end
        aux_busy[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a3_q     <= '{default: '0};
            wd_q     <= '{default: '0};
            pc_q     <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= 4'd0;
            hold_q   <= 1'b0;
        end else begin
            a3_q     <= a3_d;
            wd_q     <= wd_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            hold_q   <= hold_d;
        end
    end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter (DEPTH=2, STARVE_MAX=4); inputs change 1 time unit after
// each rising edge and outputs are examined 1 time unit later.
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd, pipe_pc;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_a3;
    logic [31:0] aux_wd, aux_pc;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc;
    logic        pipe_hold;
    logic [31:0] aux_busy;
    logic [1:0]  aux_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    grf_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
        .aux_valid(aux_valid), .aux_ready(aux_ready),
        .aux_a3(aux_a3), .aux_wd(aux_wd), .aux_pc(aux_pc),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .pipe_hold(pipe_hold), .aux_busy(aux_busy), .aux_count(aux_count)
    );

    always @(negedge clk) begin
        if (!reset) begin
            assert (!(pipe_hold && pipe_we)) else $error("protocol: pipe_we high while pipe_hold");
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pipe_we = 1'b1; pipe_a3 = 5'd3; pipe_wd = 32'h11; pipe_pc = 32'h22;
        aux_valid = 1'b1; aux_a3 = 5'd4; aux_wd = 32'h33; aux_pc = 32'h44;
        step(); step();
        #1;
        n_cmp++; if (aux_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %0d want 0", aux_ready); end
        n_cmp++; if (grf_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %0d want 0", grf_we); end
        n_cmp++; if (grf_a3 !== 5'd0 || grf_wd !== 32'd0 || grf_pc !== 32'd0) begin n_fail++; $display("FAIL rst_grf got a3=%0d wd=%h pc=%h want zeros", grf_a3, grf_wd, grf_pc); end
        n_cmp++; if (pipe_hold !== 1'b0) begin n_fail++; $display("FAIL rst_hold got %0d want 0", pipe_hold); end
        n_cmp++; if (aux_busy !== 32'd0) begin n_fail++; $display("FAIL rst_busy got %h want 0", aux_busy); end
        n_cmp++; if (aux_count !== 2'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", aux_count); end
        pipe_we = 1'b0; aux_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_pipe_only();
        pipe_we = 1'b1; pipe_a3 = 5'd5; pipe_wd = 32'h1234; pipe_pc = 32'h3000;
        #1;
        n_cmp++; if (grf_we !== 1'b1) begin n_fail++; $display("FAIL pipe_we got %0d want 1", grf_we); end
        n_cmp++; if (grf_a3 !== 5'd5) begin n_fail++; $display("FAIL pipe_a3 got %0d want 5", grf_a3); end
        n_cmp++; if (grf_wd !== 32'h1234) begin n_fail++; $display("FAIL pipe_wd got %h want 1234", grf_wd); end
        n_cmp++; if (grf_pc !== 32'h3000) begin n_fail++; $display("FAIL pipe_pc got %h want 3000", grf_pc); end
        step();
        n_cmp++; if (aux_count !== 2'd0) begin n_fail++; $display("FAIL pipe_count got %0d want 0", aux_count); end
        pipe_we = 1'b0;
    endtask

    task automatic test_aux_idle();
        pipe_we = 1'b0; aux_valid = 1'b1; aux_a3 = 5'd8; aux_wd = 32'hAA; aux_pc = 32'h4000;
        #1;
        n_cmp++; if (aux_ready !== 1'b1) begin n_fail++; $display("FAIL aux_ready got %0d want 1", aux_ready); end
        n_cmp++; if (grf_we !== 1'b0) begin n_fail++; $display("FAIL aux_nobypass got %0d want 0", grf_we); end
        step();
        aux_valid = 1'b0;
        #1;
        n_cmp++; if (aux_busy !== 32'h100) begin n_fail++; $display("FAIL aux_busy got %h want 100", aux_busy); end
        n_cmp++; if (aux_count !== 2'd1) begin n_fail++; $display("FAIL aux_count1 got %0d want 1", aux_count); end
        n_cmp++; if (grf_we !== 1'b1 || grf_a3 !== 5'd8) begin n_fail++; $display("FAIL aux_grant got we=%0d a3=%0d want 1/8", grf_we, grf_a3); end
        n_cmp++; if (grf_wd !== 32'hAA || grf_pc !== 32'h4000) begin n_fail++; $display("FAIL aux_data got wd=%h pc=%h want aa/4000", grf_wd, grf_pc); end
        step();
        n_cmp++; if (aux_count !== 2'd0 || aux_busy !== 32'd0) begin n_fail++; $display("FAIL aux_drain got cnt=%0d busy=%h want 0/0", aux_count, aux_busy); end
        n_cmp++; if (grf_we !== 1'b0) begin n_fail++; $display("FAIL aux_idle_we got %0d want 0", grf_we); end
    endtask

    task automatic test_full();
        pipe_we = 1'b1; pipe_a3 = 5'd1; pipe_wd = 32'h77; pipe_pc = 32'h5000;
        aux_valid = 1'b1; aux_a3 = 5'd10; aux_wd = 32'hA0; aux_pc = 32'h6000;
        step();
        aux_a3 = 5'd11; aux_wd = 32'hB0; aux_pc = 32'h6004;
        #1;
        n_cmp++; if (grf_a3 !== 5'd1) begin n_fail++; $display("FAIL full_pipe_wins got %0d want 1", grf_a3); end
        step();
        aux_a3 = 5'd12; aux_wd = 32'hC0; aux_pc = 32'h6008;
        #1;
        n_cmp++; if (aux_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0d want 0", aux_ready); end
        n_cmp++; if (aux_busy !== 32'h0C00) begin n_fail++; $display("FAIL full_busy got %h want c00", aux_busy); end
        step();
        n_cmp++; if (aux_count !== 2'd2) begin n_fail++; $display("FAIL full_count got %0d want 2", aux_count); end
        pipe_we = 1'b0;
        #1;
        n_cmp++; if (aux_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready got %0d want 0", aux_ready); end
        n_cmp++; if (grf_we !== 1'b1 || grf_a3 !== 5'd10) begin n_fail++; $display("FAIL full_head0 got we=%0d a3=%0d want 1/10", grf_we, grf_a3); end
        step();
        aux_valid = 1'b0;
        n_cmp++; if (aux_count !== 2'd1) begin n_fail++; $display("FAIL full_pop_count got %0d want 1", aux_count); end
        #1;
        n_cmp++; if (grf_a3 !== 5'd11 || grf_wd !== 32'hB0) begin n_fail++; $display("FAIL full_head1 got a3=%0d wd=%h want 11/b0", grf_a3, grf_wd); end
        step();
        n_cmp++; if (aux_count !== 2'd0) begin n_fail++; $display("FAIL full_empty got %0d want 0", aux_count); end
    endtask

    task automatic test_starve();
        pipe_we = 1'b1; pipe_a3 = 5'd2; pipe_wd = 32'h99; pipe_pc = 32'h7000;
        aux_valid = 1'b1; aux_a3 = 5'd9; aux_wd = 32'h900; aux_pc = 32'h8000;
        step();
        aux_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_cmp++; if (pipe_hold !== 1'b0 || grf_a3 !== 5'd2) begin n_fail++; $display("FAIL starve_blk%0d got hold=%0d a3=%0d want 0/2", i, pipe_hold, grf_a3); end
            step();
        end
        n_cmp++; if (pipe_hold !== 1'b1) begin n_fail++; $display("FAIL starve_hold got %0d want 1", pipe_hold); end
        pipe_we = 1'b0;
        #1;
        n_cmp++; if (grf_we !== 1'b1 || grf_a3 !== 5'd9 || grf_wd !== 32'h900) begin n_fail++; $display("FAIL starve_head got we=%0d a3=%0d wd=%h want 1/9/900", grf_we, grf_a3, grf_wd); end
        step();
        n_cmp++; if (pipe_hold !== 1'b0 || aux_count !== 2'd0) begin n_fail++; $display("FAIL starve_after got hold=%0d cnt=%0d want 0/0", pipe_hold, aux_count); end
    endtask

    task automatic test_async_reset();
        pipe_we = 1'b1; pipe_a3 = 5'd3; pipe_wd = 32'h5; pipe_pc = 32'h9000;
        aux_valid = 1'b1; aux_a3 = 5'd20; aux_wd = 32'h2000;
        step();
        aux_a3 = 5'd21; aux_wd = 32'h2100;
        step();
        aux_valid = 1'b0;
        n_cmp++; if (aux_count !== 2'd2) begin n_fail++; $display("FAIL ar_queued got %0d want 2", aux_count); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (aux_count !== 2'd0) begin n_fail++; $display("FAIL ar_count got %0d want 0", aux_count); end
        n_cmp++; if (aux_busy !== 32'd0) begin n_fail++; $display("FAIL ar_busy got %h want 0", aux_busy); end
        n_cmp++; if (grf_we !== 1'b0) begin n_fail++; $display("FAIL ar_we got %0d want 0", grf_we); end
        #1 reset = 1'b0; pipe_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            n_cmp++; if (grf_we !== 1'b0) begin n_fail++; $display("FAIL ar_ghost%0d got we=%0d a3=%0d want 0", i, grf_we, grf_a3); end
        end
    endtask

    task automatic test_zero_dest();
        pipe_we = 1'b0; aux_valid = 1'b1; aux_a3 = 5'd0; aux_wd = 32'h55; aux_pc = 32'hA000;
        step();
        aux_valid = 1'b0;
        #1;
        n_cmp++; if (aux_busy !== 32'd0) begin n_fail++; $display("FAIL zero_busy got %h want 0", aux_busy); end
        n_cmp++; if (aux_count !== 2'd1) begin n_fail++; $display("FAIL zero_count got %0d want 1", aux_count); end
        n_cmp++; if (grf_we !== 1'b1 || grf_a3 !== 5'd0 || grf_wd !== 32'h55) begin n_fail++; $display("FAIL zero_grant got we=%0d a3=%0d wd=%h want 1/0/55", grf_we, grf_a3, grf_wd); end
        step();
        n_cmp++; if (aux_count !== 2'd0) begin n_fail++; $display("FAIL zero_drain got %0d want 0", aux_count); end
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_aux_idle();
        test_full();
        test_starve();
        test_async_reset();
        test_zero_dest();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
